// File: rtl/branch_flag_ctrl_pkg.sv
// rtl/branch_flag_ctrl_pkg.sv - shared encodings for branch_flag_ctrl (BRANCH_FLAG_FORWARD_EN option)
package branch_flag_ctrl_pkg;

  localparam logic [2:0] BCOND_OP_NONE   = 3'd0;
  localparam logic [2:0] BCOND_OP_BRANCH = 3'd1;
  localparam logic [2:0] BCOND_OP_ZERO   = 3'd2;
  localparam logic [2:0] BCOND_OP_NZERO  = 3'd3;
  localparam logic [2:0] BCOND_OP_ALU    = 3'd4;
  localparam logic [2:0] BCOND_OP_COND   = 3'd5;

  localparam logic [3:0] BCOND_EQ = 4'h0;
  localparam logic [3:0] BCOND_NE = 4'h1;
  localparam logic [3:0] BCOND_CS = 4'h2;
  localparam logic [3:0] BCOND_CC = 4'h3;
  localparam logic [3:0] BCOND_MI = 4'h4;
  localparam logic [3:0] BCOND_PL = 4'h5;
  localparam logic [3:0] BCOND_VS = 4'h6;
  localparam logic [3:0] BCOND_VC = 4'h7;
  localparam logic [3:0] BCOND_HI = 4'h8;
  localparam logic [3:0] BCOND_LS = 4'h9;
  localparam logic [3:0] BCOND_GE = 4'hA;
  localparam logic [3:0] BCOND_LT = 4'hB;
  localparam logic [3:0] BCOND_GT = 4'hC;
  localparam logic [3:0] BCOND_LE = 4'hD;
  localparam logic [3:0] BCOND_AL = 4'hE;
  localparam logic [3:0] BCOND_NV = 4'hF;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_REL = 2'b01;
  localparam logic [1:0] PC_SRC_REG = 2'b10;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_WAIT_FLAGS = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  // Register-indirect branches (BR) take the register target; all others are PC-relative.
  function automatic logic [1:0] op_pc_src(input logic [2:0] op);
    return (op == BCOND_OP_ALU) ? PC_SRC_REG : PC_SRC_REL;
  endfunction

endpackage

// File: rtl/branch_flag_ctrl_cond_eval.sv
// rtl/branch_flag_ctrl_cond_eval.sv - combinational condition-code evaluator (cond_eval)
module branch_flag_ctrl_cond_eval
  import branch_flag_ctrl_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       taken
);

  logic n;
  logic z;
  logic c;
  logic v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    taken = 1'b0;
    case (cond)
      BCOND_EQ: taken = z;
      BCOND_NE: taken = !z;
      BCOND_CS: taken = c;
      BCOND_CC: taken = !c;
      BCOND_MI: taken = n;
      BCOND_PL: taken = !n;
      BCOND_VS: taken = v;
      BCOND_VC: taken = !v;
      BCOND_HI: taken = c && !z;
      BCOND_LS: taken = !c || z;
      BCOND_GE: taken = (n == v);
      BCOND_LT: taken = (n != v);
      BCOND_GT: taken = !z && (n == v);
      BCOND_LE: taken = z || (n != v);
      BCOND_AL: taken = 1'b1;
      BCOND_NV: taken = 1'b0;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_flag_ctrl.sv
// rtl/branch_flag_ctrl.sv - branch resolution, NZVC flag register and flush sequencing
// Optional build macro: BRANCH_FLAG_FORWARD_EN (forward flag_in to COND requests instead of stalling).
module branch_flag_ctrl
  import branch_flag_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flag_we,
  input  logic [3:0] flag_in,
  input  logic       br_valid,
  output logic       br_ready,
  input  logic [2:0] br_op,
  input  logic [4:0] br_cond,
  input  logic       reg_zero,
  output logic [1:0] pc_src,
  output logic       redirect,
  output logic       flush,
  output logic [3:0] flags_q
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [1:0]       pc_src_d;
  logic             redirect_d;
  logic [3:0]       eval_flags;
  logic             stall;
  logic             cond_taken;
  logic             taken;

`ifdef BRANCH_FLAG_FORWARD_EN
  assign eval_flags = flag_we ? flag_in : flags_q;
  assign stall      = 1'b0;
`else
  // A COND request must not see flags that the execute stage is still writing.
  assign eval_flags = flags_q;
  assign stall      = br_valid && (br_op == BCOND_OP_COND) && flag_we;
`endif

  branch_flag_ctrl_cond_eval u_cond_eval (
    .cond  (br_cond[3:0]),
    .flags (eval_flags),
    .taken (cond_taken)
  );

  always_comb begin
    taken = 1'b0;
    case (br_op)
      BCOND_OP_BRANCH: taken = 1'b1;
      BCOND_OP_ALU:    taken = 1'b1;
      BCOND_OP_ZERO:   taken = reg_zero;
      BCOND_OP_NZERO:  taken = !reg_zero;
      BCOND_OP_COND:   taken = !br_cond[4] && cond_taken;
      default:         taken = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pc_src_d   = PC_SRC_SEQ;
    redirect_d = 1'b0;
    br_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        br_ready = !stall;
        if (stall) begin
          state_d = ST_WAIT_FLAGS;
        end else if (br_valid && taken) begin
          state_d    = ST_FLUSH;
          cnt_d      = CNT_LOAD;
          pc_src_d   = op_pc_src(br_op);
          redirect_d = 1'b1;
        end
      end
      ST_WAIT_FLAGS: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        // Requests seen here are wrong-path and are dropped without acceptance.
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      pc_src   <= PC_SRC_SEQ;
      redirect <= 1'b0;
      flags_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pc_src   <= pc_src_d;
      redirect <= redirect_d;
      if (flag_we) begin
        flags_q <= flag_in;
      end
    end
  end

  assign flush = (state_q == ST_FLUSH);

endmodule
